bn_requant: RTL and testbench
=============================

# bn_requant

Folded batch-norm and requantisation stage that sits directly upstream of the `relu`/`hswish`/`hsigmoid` activation units. It takes signed convolution accumulator beats and applies a per-channel scale and bias from an internal coefficient bank. It then rounds, shifts and saturates the result to the signed DATA_WIDTH Q(FRAC_BITS) format that the activations consume. Streaming valid/ready interface, 3-stage pipeline, one beat per cycle.

## Interface
- DATA_WIDTH, 8, output width; matches activation `data_in`
- FRAC_BITS, 4, output fractional bits (documentation only; folded into coefficients)
- ACC_WIDTH, 24, signed accumulator input width
- SCALE_WIDTH, 16, signed per-channel scale width
- BIAS_WIDTH, 32, signed per-channel bias width, in product scale
- SHIFT, 12, right-shift applied after multiply-add; must be < SCALE_WIDTH-1
- NUM_CH, 16, channels in coefficient bank (≥2)

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  ACC_WIDTH  signed accumulator value
- in_sop  in  1  first beat of a pixel; forces channel index to 0 for this beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  signed requantised value
- out_sat  out  1  out_data was clipped on this beat
- out_ch  out  $clog2(NUM_CH)  channel index of this beat
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  $clog2(NUM_CH)  channel to write
- cfg_scale  in  SCALE_WIDTH  scale value
- cfg_bias  in  BIAS_WIDTH  bias value

## Operation
- Channel counter `ch`: the beat is accepted when in_valid & in_ready. Its channel is 0 if in_sop is high, otherwise `ch`. After acceptance, `ch` = used+1, wrapping NUM_CH-1 → 0. Non-accepted cycles leave `ch` unchanged.
- S1: register acc, channel, and coefficients scale[c], bias[c].
- S2: t = acc*scale + bias, full width ACC_WIDTH+SCALE_WIDTH+1 signed; no intermediate truncation.
- S3: r = (t + 2^(SHIFT-1)) >>> SHIFT, arithmetic, round-half-up. Clip to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat = 1 iff clipped.
- Coefficient bank: NUM_CH flop entries. Reset value is scale = 2^SHIFT (unity) and bias = 0. A write is accepted every cycle cfg_we=1, independent of stream handshake.
- Write/read collision: when the written address equals the address S1 reads in the same cycle, S1 gets the old value. The new value is used from the next cycle.
- Global pipeline enable en = ~out_valid | out_ready. All stages advance only when en=1. in_ready = en (combinational from out_ready). Each stage carries its own valid bit, so bubbles propagate.

## Timing
- Latency 3 cycles: a beat accepted at edge N appears on out_* after edge N+3 when out_ready stays high.
- Throughput 1 beat/cycle sustained.
- out_valid=1 & out_ready=0: out_data, out_sat and out_ch are held stable; in_ready=0; no beat lost or duplicated.
- Reset: out_valid=0, out_data=0, out_sat=0, out_ch=0, all stage valids 0, ch=0, coefficients return to unity/0. in_ready reads 1 during and after reset.
- Reset asserted mid-stream: all in-flight beats are discarded; no output beat is emitted for them.
- in_sop on a non-accepted cycle has no effect.

## Test plan
- Unity default after reset, in_data=32, out_ready=1 → out_data=32, out_sat=0, out_ch=0, exactly 3 cycles after acceptance.
- Saturation, unity coefficients, in_data=1000 then -1000 → out_data 127 then -128, out_sat=1 on both.
- Rounding: write ch0 scale=2048, bias=0. Inputs 3, -3, 5 → 2, -1, 3. Write ch0 bias=4096 → input 3 gives 3.
- Channel wrap: ch1 scale=8192, others unity. Stream 18 beats of value 10 with in_sop on beat 0 only. Beats with ch=1 (beats 1 and 17) give 20, all others 10, and out_ch sequence 0..15,0,1. Then in_sop mid-stream → that beat's out_ch=0.
- Backpressure: stream 8 distinct values, hold out_ready=0 for 5 cycles mid-stream → outputs held stable, in_ready=0, all 8 values delivered in order once released.
- Reset mid-stream with 3 beats in flight → no out_valid for those beats; coefficients return to unity; next beat in_data=7 → 7.

Source files
------------

// File: rtl/bn_requant_if.sv
// Stream and coefficient-port bundle for the bn_requant stage.
// The slave modport is the stage's own view; the master modport is the
// view of whatever drives it (upstream producer, downstream consumer and
// coefficient loader combined).
interface bn_requant_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int SCALE_WIDTH = 16,
  parameter int BIAS_WIDTH  = 32,
  parameter int NUM_CH      = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                   in_valid;
  logic                   in_ready;
  logic [ACC_WIDTH-1:0]   in_data;
  logic                   in_sop;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_sat;
  logic [CH_W-1:0]        out_ch;

  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_addr;
  logic [SCALE_WIDTH-1:0] cfg_scale;
  logic [BIAS_WIDTH-1:0]  cfg_bias;

  modport slave (
    input  in_valid, in_data, in_sop, out_ready,
    input  cfg_we, cfg_addr, cfg_scale, cfg_bias,
    output in_ready, out_valid, out_data, out_sat, out_ch
  );

  modport master (
    output in_valid, in_data, in_sop, out_ready,
    output cfg_we, cfg_addr, cfg_scale, cfg_bias,
    input  in_ready, out_valid, out_data, out_sat, out_ch
  );
endinterface

// File: rtl/bn_requant.sv
// Folded batch-norm + requantisation stage.
// Per beat: t = acc*scale[c] + bias[c] at full precision, then
// round-half-up, arithmetic shift by SHIFT, and saturate to signed
// DATA_WIDTH. Pipeline: S1 (operand/coef capture), S2 (multiply-add),
// S3 (round/shift), output register (clip). One global enable stalls
// everything when the output register is full and not being drained.
module bn_requant #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int SCALE_WIDTH = 16,
  parameter int BIAS_WIDTH  = 32,
  parameter int SHIFT       = 12,
  parameter int NUM_CH      = 16
) (
  input logic          clk,
  input logic          rst,
  bn_requant_if.slave  bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int T_W  = ACC_WIDTH + SCALE_WIDTH + 1;

  localparam logic [CH_W-1:0]               CH_ZERO     = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]               CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic signed [SCALE_WIDTH-1:0] SCALE_UNITY = SCALE_WIDTH'(64'd1 << SHIFT);
  localparam logic signed [T_W-1:0]         RND_HALF    = T_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [T_W-1:0]         OUT_MAX     = T_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [T_W-1:0]         OUT_MIN     = T_W'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  // FRAC_BITS is folded into the coefficients; it only bounds the format here.
  if (SHIFT < 1 || SHIFT >= SCALE_WIDTH - 1 || FRAC_BITS >= DATA_WIDTH ||
      NUM_CH < 2 || BIAS_WIDTH >= T_W) begin : g_param_check
    $error("bn_requant: illegal parameter combination");
  end

  logic                          en_s;
  logic                          accept_s;
  logic [CH_W-1:0]               ch_q, ch_d, ch_use_s;

  logic signed [SCALE_WIDTH-1:0] scale_q [NUM_CH];
  logic signed [BIAS_WIDTH-1:0]  bias_q  [NUM_CH];

  logic                          v1_q;
  logic signed [ACC_WIDTH-1:0]   acc1_q;
  logic [CH_W-1:0]               ch1_q;
  logic signed [SCALE_WIDTH-1:0] scale1_q;
  logic signed [BIAS_WIDTH-1:0]  bias1_q;

  logic                          v2_q;
  logic signed [T_W-1:0]         t2_q;
  logic [CH_W-1:0]               ch2_q;

  logic                          v3_q;
  logic signed [T_W-1:0]         r3_q;
  logic [CH_W-1:0]               ch3_q;

  logic                          out_valid_q;
  logic [DATA_WIDTH-1:0]         out_data_q;
  logic                          out_sat_q;
  logic [CH_W-1:0]               out_ch_q;

  logic signed [T_W-1:0]         acc_ext_s, scale_ext_s, bias_ext_s, t_s, r_s;
  logic [DATA_WIDTH-1:0]         clip_data_s;
  logic                          clip_sat_s;

  // Global enable, acceptance, and channel selection / advance.
  always_comb begin
    en_s     = ~out_valid_q | bus.out_ready;
    accept_s = bus.in_valid & en_s;
    if (bus.in_sop) begin
      ch_use_s = CH_ZERO;
    end else begin
      ch_use_s = ch_q;
    end
    if (!accept_s) begin
      ch_d = ch_q;
    end else if (ch_use_s == CH_LAST) begin
      ch_d = CH_ZERO;
    end else begin
      ch_d = ch_use_s + CH_W'(1'b1);
    end
  end

  // Channel counter; only an accepted beat moves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q <= CH_ZERO;
    end else begin
      ch_q <= ch_d;
    end
  end

  // Coefficient bank; writes land at the edge, so a same-cycle S1 read sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_q[i] <= SCALE_UNITY;
        bias_q[i]  <= {BIAS_WIDTH{1'b0}};
      end
    end else if (bus.cfg_we) begin
      scale_q[bus.cfg_addr] <= bus.cfg_scale;
      bias_q[bus.cfg_addr]  <= bus.cfg_bias;
    end
  end

  // Full-precision multiply-add (S2 input) and round/shift (S3 input).
  always_comb begin
    acc_ext_s   = {{(T_W - ACC_WIDTH){acc1_q[ACC_WIDTH-1]}}, acc1_q};
    scale_ext_s = {{(T_W - SCALE_WIDTH){scale1_q[SCALE_WIDTH-1]}}, scale1_q};
    bias_ext_s  = {{(T_W - BIAS_WIDTH){bias1_q[BIAS_WIDTH-1]}}, bias1_q};
    t_s         = (acc_ext_s * scale_ext_s) + bias_ext_s;
    r_s         = (t2_q + RND_HALF) >>> SHIFT;
  end

  // Saturation to the signed output range.
  always_comb begin
    if (r3_q > OUT_MAX) begin
      clip_data_s = OUT_MAX[DATA_WIDTH-1:0];
      clip_sat_s  = 1'b1;
    end else if (r3_q < OUT_MIN) begin
      clip_data_s = OUT_MIN[DATA_WIDTH-1:0];
      clip_sat_s  = 1'b1;
    end else begin
      clip_data_s = r3_q[DATA_WIDTH-1:0];
      clip_sat_s  = 1'b0;
    end
  end

  // Pipeline registers; every stage advances together under the global enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      acc1_q      <= {ACC_WIDTH{1'b0}};
      ch1_q       <= CH_ZERO;
      scale1_q    <= {SCALE_WIDTH{1'b0}};
      bias1_q     <= {BIAS_WIDTH{1'b0}};
      v2_q        <= 1'b0;
      t2_q        <= {T_W{1'b0}};
      ch2_q       <= CH_ZERO;
      v3_q        <= 1'b0;
      r3_q        <= {T_W{1'b0}};
      ch3_q       <= CH_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_sat_q   <= 1'b0;
      out_ch_q    <= CH_ZERO;
    end else if (en_s) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        acc1_q   <= bus.in_data;
        ch1_q    <= ch_use_s;
        scale1_q <= scale_q[ch_use_s];
        bias1_q  <= bias_q[ch_use_s];
      end
      v2_q <= v1_q;
      if (v1_q) begin
        t2_q  <= t_s;
        ch2_q <= ch1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        r3_q  <= r_s;
        ch3_q <= ch2_q;
      end
      out_valid_q <= v3_q;
      if (v3_q) begin
        out_data_q <= clip_data_s;
        out_sat_q  <= clip_sat_s;
        out_ch_q   <= ch3_q;
      end
    end
  end

  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_bn_requant.sv
// Scoreboard bench for bn_requant: a recorder pushes the expected result
// of every accepted beat (transaction-level arithmetic model or a fixed
// expected value for directed beats); an output monitor pops and compares.
module tb_bn_requant;
  localparam int DW = 8, AW = 24, SW = 16, BW = 32, SH = 12, NCH = 16;

  typedef struct {
    longint data;
    longint sat;
    longint ch;
    longint edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bn_requant_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SCALE_WIDTH(SW),
                  .BIAS_WIDTH(BW), .NUM_CH(NCH)) bus ();

  bn_requant #(.DATA_WIDTH(DW), .FRAC_BITS(4), .ACC_WIDTH(AW), .SCALE_WIDTH(SW),
               .BIAS_WIDTH(BW), .SHIFT(SH), .NUM_CH(NCH))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint last_stall = -1;

  longint m_scale [NCH];
  longint m_bias  [NCH];
  int     m_ch;

  bit     lit_en = 1'b0;
  longint lit_data, lit_sat, lit_ch;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic signed [63:0] act, longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_scale[i] = 4096;
      m_bias[i]  = 0;
    end
    m_ch = 0;
  endfunction

  // Recorder: model each accepted beat, then apply any coefficient write.
  always @(negedge clk) begin
    int     c;
    longint t, r;
    exp_t   e;
    if (rst) begin
      sb_q.delete();
      model_reset();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        c = bus.in_sop ? 0 : m_ch;
        t = longint'($signed(bus.in_data)) * m_scale[c] + m_bias[c];
        r = (t + 2048) >>> SH;
        if (r > 127)       begin e.data = 127;  e.sat = 1; end
        else if (r < -128) begin e.data = -128; e.sat = 1; end
        else               begin e.data = r;    e.sat = 0; end
        e.ch = c;
        if (lit_en) begin
          e.data = lit_data;
          e.sat  = lit_sat;
          e.ch   = lit_ch;
        end
        e.edge_n = cyc + 1;
        sb_q.push_back(e);
        m_ch = (c + 1) % NCH;
      end
      if (bus.cfg_we) begin
        m_scale[bus.cfg_addr] = longint'($signed(bus.cfg_scale));
        m_bias[bus.cfg_addr]  = longint'($signed(bus.cfg_bias));
      end
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_sat;
  logic [3:0]    prev_ch;

  // Output monitor: stall stability, in_ready under stall, and scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", $signed(bus.out_data), longint'($signed(prev_data)));
        chk("hold_sat", bus.out_sat, longint'(prev_sat));
        chk("hold_ch", bus.out_ch, longint'(prev_ch));
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", bus.in_ready, 0);
        last_stall = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_out: got beat data=%0d with no expected beat (cycle %0d)",
                   $signed(bus.out_data), cyc);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", $signed(bus.out_data), e.data);
          chk("out_sat", bus.out_sat, e.sat);
          chk("out_ch", bus.out_ch, e.ch);
          if (last_stall < e.edge_n) chk("latency", cyc - e.edge_n, 3);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_sat   = bus.out_sat;
      prev_ch    = bus.out_ch;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(longint d, bit sop, bit lit, longint ld, longint ls, longint lc);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = AW'(d);
    bus.in_sop   = sop;
    lit_en   = lit;
    lit_data = ld;
    lit_sat  = ls;
    lit_ch   = lc;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: beat %0d not accepted, expected acceptance within 200 cycles", d);
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    lit_en       = 1'b0;
  endtask

  task automatic cfg_write(int addr, longint sc, longint bi);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'(addr);
    bus.cfg_scale = SW'(sc);
    bus.cfg_bias  = BW'(bi);
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) tick();
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic check_idle_state(string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_sat"}, bus.out_sat, 0);
    chk({tag, "_out_ch"}, bus.out_ch, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_scale = '0; bus.cfg_bias = '0;
    repeat (3) tick();
    check_idle_state("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready", bus.in_ready, 1);

    // Unity default, latency checked by the monitor.
    send(32, 1'b1, 1'b1, 32, 0, 0);
    drain();

    // Saturation at both rails.
    send(1000, 1'b1, 1'b1, 127, 1, 0);
    send(-1000, 1'b1, 1'b1, -128, 1, 0);
    drain();

    // Round-half-up with half-unity scale, then with a bias.
    cfg_write(0, 2048, 0);
    send(3, 1'b1, 1'b1, 2, 0, 0);
    send(-3, 1'b1, 1'b1, -1, 0, 0);
    send(5, 1'b1, 1'b1, 3, 0, 0);
    cfg_write(0, 2048, 4096);
    send(3, 1'b1, 1'b1, 3, 0, 0);
    drain();

    // Channel wrap with ch1 at double scale, then a mid-stream restart.
    cfg_write(0, 4096, 0);
    cfg_write(1, 8192, 0);
    for (int i = 0; i < 18; i++)
      send(10, i == 0, 1'b1, ((i % 16) == 1) ? 20 : 10, 0, i % 16);
    send(10, 1'b0, 1'b1, 10, 0, 2);
    send(10, 1'b1, 1'b1, 10, 0, 0);
    send(10, 1'b0, 1'b1, 20, 0, 1);
    drain();

    // Backpressure: 5 stalled cycles mid-stream.
    cfg_write(1, 4096, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) send(11 + 7 * i, i == 0, 1'b1, 11 + 7 * i, 0, i);
      end
      begin
        repeat (4) tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight; coefficients must return to unity.
    cfg_write(0, 8192, 0);
    send(1, 1'b1, 1'b0, 0, 0, 0);
    send(2, 1'b0, 1'b0, 0, 0, 0);
    send(3, 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) tick();
    check_idle_state("midreset");
    rst = 1'b0;
    repeat (6) tick();
    send(7, 1'b1, 1'b1, 7, 0, 0);
    drain();

    // Randomised traffic, coefficients, backpressure and one reset.
    for (int n = 0; n < 1500; n++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) v = longint'($urandom_range(0, 400)) - 200;
      else v = longint'($urandom);
      bus.in_data   = AW'(v);
      bus.in_sop    = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cfg_we    = ($urandom_range(0, 7) == 0);
      bus.cfg_addr  = 4'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 1) == 1) bus.cfg_scale = SW'(longint'($urandom_range(0, 8191)) - 4096);
      else bus.cfg_scale = SW'($urandom);
      if ($urandom_range(0, 1) == 1) bus.cfg_bias = BW'(longint'($urandom_range(0, 65535)) - 32768);
      else bus.cfg_bias = BW'($urandom);
      rst = (n == 700 || n == 701);
      tick();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.cfg_we = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
